// File: rtl/alu_pkg.sv
// alu_pkg: mode codes, FSM states and compare-flag bit positions shared by alu_seq
package alu_pkg;
  localparam logic [3:0] SUB  = 4'h0;
  localparam logic [3:0] ADD  = 4'h1;
  localparam logic [3:0] AND  = 4'h2;
  localparam logic [3:0] OR   = 4'h3;
  localparam logic [3:0] XOR  = 4'h4;
  localparam logic [3:0] RMV  = 4'h5;
  localparam logic [3:0] LMV  = 4'h6;
  localparam logic [3:0] ARMV = 4'h7;
  localparam logic [3:0] MUL  = 4'h8;
  localparam logic [3:0] DIVU = 4'h9;
  localparam logic [3:0] REMU = 4'hA;
  localparam logic [3:0] TEST = 4'hF;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int SF_EQ  = 0;
  localparam int SF_SLT = 1;
  localparam int SF_ULT = 2;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-step-per-cycle shift-add multiplier and restoring divider.
// done is asserted during the final step; result/dz are valid alongside it.
module alu_muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             dz
);
  localparam int CNT_W = $clog2(WIDTH+1);
  logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, ge;
  logic [WIDTH:0]   r;
  // MUL: acc += x when y[0]; DIV: {acc,x} shifts left as partial remainder / quotient
  always_comb begin
    r     = {acc_q, x_q[WIDTH-1]};
    ge    = r >= {1'b0, y_q};
    acc_d = op_q == MUL ? acc_q + (y_q[0] ? x_q : '0) :
            ge ? WIDTH'(r - {1'b0, y_q}) : r[WIDTH-1:0];
    x_d   = op_q == MUL ? x_q << 1 : {x_q[WIDTH-2:0], ge};
    y_d   = op_q == MUL ? y_q >> 1 : y_q;
  end
  assign done   = busy_q && cnt_q == CNT_W'(WIDTH-1);
  assign result = op_q == DIVU ? x_d : acc_d;
  assign dz     = op_q != MUL && y_q == '0;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      op_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      acc_q  <= '0;
      x_q    <= a;
      y_q    <= b;
      op_q   <= op;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_q + CNT_W'(1);
      busy_q <= !done;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU; single-cycle ops complete in one cycle,
// MUL/DIVU/REMU iterate WIDTH cycles in alu_muldiv_iter.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [3:0]       mode_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic [2:0]       sub_flag,
  output logic             error,
  output logic             div_zero
);
  state_t           state_q;
  logic             in_ready_q, out_valid_q, error_q, dz_q;
  logic [WIDTH-1:0] ans_q, n1_q, n2_q, alu_d, md_res;
  logic [2:0]       flag_q;
  logic             is_md, err_d, md_start, md_done, md_dz;
  function automatic logic [2:0] flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    flags         = '0;
    flags[SF_EQ]  = a == b;
    flags[SF_SLT] = $signed(a) < $signed(b);
    flags[SF_ULT] = a < b;
  endfunction
  assign is_md    = MULDIV_EN && (mode_sel == MUL || mode_sel == DIVU || mode_sel == REMU);
  assign err_d    = !(mode_sel <= ARMV || mode_sel == TEST || is_md);
  assign md_start = state_q == IDLE && in_valid && is_md;
  // SV shift semantics already give 0 / sign-fill for amounts >= WIDTH
  always_comb begin
    alu_d = '0;
    case (mode_sel)
      SUB:     alu_d = num1 - num2;
      ADD:     alu_d = num1 + num2;
      AND:     alu_d = num1 & num2;
      OR:      alu_d = num1 | num2;
      XOR:     alu_d = num1 ^ num2;
      RMV:     alu_d = num1 >> num2;
      LMV:     alu_d = num1 << num2;
      ARMV:    alu_d = $unsigned($signed(num1) >>> num2);
      TEST:    alu_d = '1;
      default: alu_d = '0;
    endcase
  end
  if (MULDIV_EN) begin : g_md
    alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
      .clk(clk), .rstn(rstn), .start(md_start), .a(num1), .b(num2), .op(mode_sel),
      .done(md_done), .result(md_res), .dz(md_dz)
    );
  end else begin : g_no_md
    assign md_done = 1'b0;
    assign md_res  = '0;
    assign md_dz   = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ans_q       <= '0;
      flag_q      <= '0;
      error_q     <= 1'b0;
      dz_q        <= 1'b0;
      n1_q        <= '0;
      n2_q        <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          n1_q       <= num1;
          n2_q       <= num2;
          in_ready_q <= 1'b0;
          if (is_md) state_q <= BUSY;
          else begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            ans_q       <= alu_d;
            flag_q      <= flags(num1, num2);
            error_q     <= err_d;
            dz_q        <= 1'b0;
          end
        end
        BUSY: if (md_done) begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          ans_q       <= md_res;
          flag_q      <= flags(n1_q, n2_q);
          error_q     <= 1'b0;
          dz_q        <= md_dz;
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ans       = ans_q;
  assign sub_flag  = flag_q;
  assign error     = error_q;
  assign div_zero  = dz_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  logic        clk = 0, rstn, in_valid, in_valid0, out_ready;
  logic [31:0] num1, num2;
  logic [3:0]  mode_sel;
  logic        in_ready, out_valid, error, div_zero;
  logic [31:0] ans;
  logic [2:0]  sub_flag;
  logic        in_ready0, out_valid0, error0, div_zero0;
  logic [31:0] ans0;
  logic [2:0]  sub_flag0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .num1(num1), .num2(num2), .mode_sel(mode_sel), .out_valid(out_valid),
    .out_ready(out_ready), .ans(ans), .sub_flag(sub_flag), .error(error), .div_zero(div_zero)
  );
  alu_seq #(.WIDTH(32), .MULDIV_EN(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid0), .in_ready(in_ready0),
    .num1(num1), .num2(num2), .mode_sel(mode_sel), .out_valid(out_valid0),
    .out_ready(out_ready), .ans(ans0), .sub_flag(sub_flag0), .error(error0), .div_zero(div_zero0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output logic z,
                                output logic [2:0] f, output int lat);
    e = 0; z = 0; lat = 1;
    f = {a < b, $signed(a) < $signed(b), a == b};
    case (m)
      4'h0: r = a - b;
      4'h1: r = a + b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = b >= 32 ? 32'h0 : a >> b;
      4'h6: r = b >= 32 ? 32'h0 : a << b;
      4'h7: r = b >= 32 ? {32{a[31]}} : (a >> b) | (a[31] ? ~(32'hFFFF_FFFF >> b) : 32'h0);
      4'h8: begin r = a * b; lat = 33; end
      4'h9: begin r = b == 0 ? 32'hFFFF_FFFF : a / b; z = b == 0; lat = 33; end
      4'hA: begin r = b == 0 ? a : a % b; z = b == 0; lat = 33; end
      4'hF: r = 32'hFFFF_FFFF;
      default: begin r = 0; e = 1; end
    endcase
  endfunction

  task automatic run_op(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ee, ez;
    logic [2:0]  ef;
    int          el, lat;
    bit          rdy;
    model(m, a, b, er, ee, ez, ef, el);
    @(negedge clk);
    lat = 0;
    while (!in_ready && lat < 100) begin @(negedge clk); lat++; end
    check("in_ready_idle", in_ready, 1);
    mode_sel = m; num1 = a; num2 = b; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0; num1 = $urandom; num2 = $urandom; mode_sel = 4'($urandom);
    lat = 0; rdy = 0;
    do begin @(negedge clk); lat++; if (in_ready) rdy = 1; end while (!out_valid && lat < 100);
    check($sformatf("latency m=%0h", m), lat, el);
    check("in_ready_busy", rdy, 0);
    check($sformatf("ans m=%0h a=%0h b=%0h", m, a, b), ans, er);
    check($sformatf("sub_flag m=%0h", m), sub_flag, ef);
    check($sformatf("error m=%0h", m), error, ee);
    check($sformatf("div_zero m=%0h", m), div_zero, ez);
    if (out_ready) begin
      @(negedge clk);
      check("consumed_valid", out_valid, 0);
      check("consumed_ready", in_ready, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held, a, b;
    logic [3:0]  m;
    bit          seen;
    rstn = 0; in_valid = 0; in_valid0 = 0; out_ready = 1;
    num1 = 0; num2 = 0; mode_sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst ans", ans, 0);
    check("rst sub_flag", sub_flag, 0);
    check("rst error", error, 0);
    check("rst div_zero", div_zero, 0);
    rstn = 1;

    run_op(4'h1, 5, 7);
    check("add flags literal", sub_flag, 3'b110);
    run_op(4'h7, 32'h8000_0000, 4);
    run_op(4'h7, 32'h8000_0000, 40);
    run_op(4'h6, 1, 32);
    run_op(4'h5, 32'hF000_0000, 31);
    run_op(4'h8, 32'hFFFF_FFFF, 3);
    run_op(4'h9, 100, 7);
    run_op(4'hA, 100, 7);
    run_op(4'h9, 9, 0);
    run_op(4'hA, 9, 0);
    run_op(4'hB, 1, 2);
    run_op(4'hF, 0, 0);

    // backpressure: result must hold while a stray in_valid pulse is ignored
    out_ready = 0;
    run_op(4'h0, 3, 5);
    held = ans;
    check("bp ans literal", held, 32'hFFFF_FFFE);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin mode_sel = 4'h1; num1 = 1; num2 = 1; in_valid = 1; end
      @(posedge clk);
      #1 in_valid = 0;
      @(negedge clk);
      check("bp out_valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
      check("bp ans", ans, held);
    end
    out_ready = 1;
    @(negedge clk);
    check("bp consumed", out_valid, 0);
    check("bp ready", in_ready, 1);
    @(negedge clk);
    check("bp no ghost", out_valid, 0);

    // reset mid-MUL aborts without producing a result
    mode_sel = 4'h8; num1 = 32'h1234; num2 = 32'h5678; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (10) @(negedge clk);
    rstn = 0;
    @(negedge clk);
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    check("abort ans", ans, 0);
    rstn = 1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1; end
    check("abort no result", seen, 0);
    run_op(4'hB, 7, 7);

    // MULDIV_EN=0 reports MUL as an error in one cycle
    @(negedge clk);
    mode_sel = 4'h8; num1 = 6; num2 = 7; in_valid0 = 1;
    @(posedge clk);
    #1 in_valid0 = 0;
    @(negedge clk);
    check("noMD out_valid", out_valid0, 1);
    check("noMD error", error0, 1);
    check("noMD ans", ans0, 0);
    check("noMD div_zero", div_zero0, 0);
    @(negedge clk);
    check("noMD ready", in_ready0, 1);

    for (int i = 0; i < 40; i++) begin
      m = 4'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 40);
        1: b = (i % 5 == 0) ? 0 : $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      run_op(m, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Multi-cycle, handshaked successor to the combinational ALU. It keeps the same mode encoding (SUB..ARMV, TEST) and compare flags, and adds iterative multiply, unsigned divide and unsigned remainder. Operands enter through a valid/ready input port. Results leave through a valid/ready output port and are held under backpressure. It sits between the register-read stage and write-back in the multi-cycle CPU datapath.

Parameters:
WIDTH, 32, operand and result width in bits (>= 4).
MULDIV_EN, 1, 1 = modes 8/9/A implemented; 0 = those modes report error.
Local parameter CNT_W = $clog2(WIDTH+1), width of the iteration counter.

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  synchronous, active-low reset.
in_valid  input  1  operands and mode are valid.
in_ready  output  1  block accepts a new operation.
num1  input  WIDTH  source operand 1.
num2  input  WIDTH  source operand 2 (shift amount for modes 5/6/7).
mode_sel  input  4  operation select.
out_valid  output  1  result is valid.
out_ready  input  1  consumer takes the result.
ans  output  WIDTH  result.
sub_flag  output  3  [0] equal, [1] signed less-than, [2] unsigned less-than (num1 vs num2).
error  output  1  undefined or disabled mode.
div_zero  output  1  DIVU/REMU issued with num2 == 0.

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rstn).
- Reset (rstn=0 at a clk edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, ans=0, sub_flag=0, error=0, div_zero=0.
  - Internal counter and accumulators are cleared.
  - Reset aborts any in-flight MUL/DIV with no output produced.
- Modes:
  - 0 SUB, 1 ADD, 2 AND, 3 OR, 4 XOR: standard results, all taken modulo 2^WIDTH.
  - 5 RMV (logical right shift), 6 LMV (logical left shift), 7 ARMV (arithmetic right shift).
  - 8 MUL: low WIDTH bits of the unsigned product.
  - 9 DIVU: unsigned quotient. A (hex) REMU: unsigned remainder.
  - F TEST: all ones.
  - Any other code, or 8/9/A when MULDIV_EN=0: ans=0, error=1, latency 1.
- Shifts: only num2 >= WIDTH is special. RMV/LMV then give 0. ARMV then gives all copies of num1[WIDTH-1]. Otherwise ARMV fills vacated bits with num1[WIDTH-1].
- Divide by zero: DIVU gives all ones, REMU gives num1, and div_zero=1. Latency is still the normal MUL/DIV latency (no early exit).
- sub_flag is computed on the latched operands and presented with every result, whatever the mode.
- State machine (IDLE, BUSY, DONE):
  - IDLE: in_ready=1. When in_valid=1, latch num1, num2 and mode_sel.
    - Single-cycle modes: compute and go to DONE. out_valid=1 on the cycle after acceptance (latency 1).
    - MUL/DIVU/REMU: go to BUSY with counter=0.
  - BUSY: in_ready=0. MUL does one shift-add step per cycle; DIVU/REMU do one restoring-division step per cycle. After WIDTH steps, go to DONE. out_valid rises WIDTH+1 cycles after acceptance.
  - DONE: out_valid=1, in_ready=0. ans, sub_flag, error and div_zero stay stable until out_ready=1. On that cycle the result is consumed and the state returns to IDLE. in_ready=1 on the following cycle (no bypass; at most one operation in flight).
- out_valid must never drop without out_ready. in_valid is ignored while in_ready=0.
- error and div_zero are qualified by out_valid and retain their value until the next result.

Decomposition:
- Shared package alu_pkg holds:
  - the mode localparams (SUB=0 .. REMU=A, TEST=F);
  - state encodings IDLE/BUSY/DONE;
  - the sub_flag bit indices.
- One sub-module, alu_muldiv_iter, holds the shift-add multiplier and restoring divider datapath.
  - Inputs: start, a, b, op.
  - Outputs: done, result, dz.
  - Parameterised by WIDTH.
- The top level keeps the FSM, handshakes, single-cycle ops and flags.

Test Plan:
- ADD num1=5, num2=7, out_ready=1 -> out_valid exactly 1 cycle after acceptance; ans=12, sub_flag=3'b110, error=0.
- ARMV num1=0x80000000, num2=4 -> ans=0xF8000000. Same with num2=40 -> ans=0xFFFFFFFF. LMV num1=1, num2=32 -> ans=0.
- MUL 0xFFFFFFFF*3 -> ans=0xFFFFFFFD, out_valid at cycle 33 after acceptance; in_ready=0 throughout.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF with div_zero=1; REMU 9/0 -> 9 with div_zero=1.
- Backpressure: SUB 3-5 with out_ready=0 for 5 cycles -> ans=0xFFFFFFFE stable and in_ready=0; a new in_valid pulse is ignored; result is consumed when out_ready rises.
- rstn=0 at cycle 10 of a MUL -> next cycle in_ready=1, out_valid=0. Then mode_sel=0xB -> ans=0, error=1. With MULDIV_EN=0, mode 8 -> error=1.
